// File: rtl/ysyx_22040386_ifu.sv
// NPC instruction fetch unit: owns the PC, fetches over imem, hands words to decode.
// Optional: YSYX_22040386_IFU_EBREAK_HALT_EN stops fetching after an ebreak is delivered.
module ysyx_22040386_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [63:0] r_pc;
  logic [63:0] w_pc_n;
  logic [63:0] r_inst_pc;
  logic [63:0] w_inst_pc_n;
  logic [31:0] r_inst;
  logic [31:0] w_inst_n;
  logic        r_kill;
  logic        w_kill_n;
  logic        r_fault;
  logic        w_fault_n;
  logic        r_inst_valid;
  logic        r_halted;
  logic        w_halted_n;
  logic        w_redir;
  logic        w_misal;

`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  logic r_ebrk;
  logic w_ebrk_n;
`endif

  assign w_redir = redirect_valid && (r_state != S_HALT);
  assign w_misal = redirect_pc[1:0] != 2'b00;

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_inst_n    = r_inst;
    w_inst_pc_n = r_inst_pc;
    w_kill_n    = r_kill;
    w_fault_n   = r_fault;
`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
    w_ebrk_n    = r_ebrk;
`endif
    if (w_redir && w_misal) begin
      // bad target: keep pc, stop for good
      w_state_n = S_HALT;
      w_fault_n = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_n = S_REQ;
          if (w_redir) w_pc_n = redirect_pc;
        end
        S_REQ: begin
          if (w_redir) w_pc_n = redirect_pc;
          if (imem_req_ready) begin
            w_state_n = S_WAIT;
            w_kill_n  = w_redir;
          end
        end
        S_WAIT: begin
          if (w_redir) begin
            w_pc_n = redirect_pc;
            if (imem_rsp_valid) begin
              w_kill_n  = 1'b0;
              w_state_n = S_REQ;
            end else begin
              w_kill_n = 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (r_kill) begin
              w_kill_n  = 1'b0;
              w_state_n = S_REQ;
            end else if (imem_rsp_err) begin
              w_fault_n = 1'b1;
              w_state_n = S_HALT;
            end else begin
              w_inst_n    = imem_rsp_data;
              w_inst_pc_n = r_pc;
              w_state_n   = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (w_redir) begin
            w_pc_n    = redirect_pc;
            w_state_n = S_REQ;
          end else if (inst_ready) begin
            w_pc_n    = r_pc + 64'd4;
            w_state_n = S_REQ;
`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
            if (r_inst == EBREAK) begin
              w_state_n = S_HALT;
              w_ebrk_n  = 1'b1;
            end
`endif
          end
        end
        S_HALT: begin
          w_state_n = S_HALT;
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
  assign w_halted_n = w_fault_n | w_ebrk_n;
`else
  assign w_halted_n = w_fault_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_inst_pc    <= 64'd0;
      r_kill       <= 1'b0;
      r_fault      <= 1'b0;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_inst       <= w_inst_n;
      r_inst_pc    <= w_inst_pc_n;
      r_kill       <= w_kill_n;
      r_fault      <= w_fault_n;
      r_inst_valid <= (w_state_n == S_OUT);
      r_halted     <= w_halted_n;
    end
  end

`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ebrk <= 1'b0;
    else        r_ebrk <= w_ebrk_n;
  end
`endif

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_fault    = r_fault;
  assign halted         = r_halted;

endmodule

// File: tb/tb_ysyx_22040386_ifu.sv
// Scoreboard bench for ysyx_22040386_ifu: random memory/decoder/redirect driver,
// program-order PC model, monitor checks every delivered instruction.
`timescale 1ns/1ps
module tb_ysyx_22040386_ifu;

  localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_fault;
  logic        halted;

  ysyx_22040386_ifu #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // driver knobs
  int          k_rdy = 100;
  int          k_irdy = 100;
  int          k_redir = 0;
  int          k_dmin = 1;
  int          k_dmax = 1;
  int          err_nth = 0;
  logic [63:0] ebrk_addr = '1;
  bit          one_redir = 0;
  logic [63:0] one_redir_pc = '0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_pc = RPC;
  int          hs_n = 0;
  int          hs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_of(input logic [63:0] a);
    logic [31:0] w;
    if (a == ebrk_addr) return EBRK;
    w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    if (w == EBRK) w = w ^ 32'h1;
    return w;
  endfunction

  // memory, decoder and redirect stimulus; also feeds the scoreboard
  logic        acc_s;
  logic [63:0] acc_addr;
  bit          pend;
  int          pcnt;
  logic [63:0] paddr;
  int          rsp_n;
  bit          redir_prev;
  logic [63:0] redir_prev_pc;

  initial begin
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data  = 0;
    imem_rsp_err   = 0;
    inst_ready     = 0;
    redirect_valid = 0;
    redirect_pc    = 0;
    pend = 0; pcnt = 0; paddr = 0; rsp_n = 0;
    redir_prev = 0; redir_prev_pc = 0;
    forever begin
      @(negedge clk);
      acc_s    = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend = 0; rsp_n = 0; redir_prev = 0;
        imem_rsp_valid = 0; imem_rsp_err = 0; redirect_valid = 0;
        sb.delete();
        model_pc = RPC;
        continue;
      end
      if (redir_prev) begin
        sb.delete();
        model_pc = redir_prev_pc;
      end
      redir_prev = 0;
      if (acc_s) begin
        chk("one_outstanding", 64'(pend), 64'd0);
        pend  = 1;
        paddr = acc_addr;
        pcnt  = $urandom_range(k_dmax, k_dmin);
      end
      imem_rsp_valid = 0;
      imem_rsp_err   = 0;
      imem_rsp_data  = $urandom;
      if (pend) begin
        if (pcnt <= 1) begin
          pend = 0;
          rsp_n++;
          imem_rsp_valid = 1;
          imem_rsp_data  = mem_of(paddr);
          imem_rsp_err   = (rsp_n == err_nth);
        end else begin
          pcnt--;
        end
      end
      imem_req_ready = ($urandom_range(99) < k_rdy);
      inst_ready     = ($urandom_range(99) < k_irdy);
      redirect_valid = 0;
      if (one_redir) begin
        one_redir      = 0;
        redirect_valid = 1;
        redirect_pc    = one_redir_pc;
      end else if ($urandom_range(99) < k_redir) begin
        redirect_valid = 1;
        if ($urandom_range(15) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        else redirect_pc = RPC + 64'($urandom_range(4095)) * 64'd4;
      end
      if (redirect_valid && !halted) begin
        redir_prev    = (redirect_pc[1:0] == 2'b00);
        redir_prev_pc = redirect_pc;
      end
      while (sb.size() < 2) begin
        sb.push_back('{model_pc, mem_of(model_pc)});
        model_pc = model_pc + 64'd4;
      end
    end
  end

  // monitor: every decoder handshake is checked against the program-order model
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready) begin
        hs_n++;
        hs_cyc = cyc;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_empty: delivered pc %h with no expectation", inst_pc);
        end else begin
          e = sb.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", 64'(inst), 64'(e.w));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int b = 0;
    while (hs_n < target && b < budget) begin
      tick();
      b++;
    end
    n_chk++;
    if (hs_n >= target) n_pass++;
    else $display("FAIL %s: handshakes %0d expected %0d", name, hs_n, target);
  endtask

  task automatic count_req(input int n, input string name);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (imem_req_valid) c++;
    end
    chk(name, 64'(c), 64'd0);
  endtask

  task automatic rst_on();
    tick();
    rst_n = 0;
    k_rdy = 100; k_irdy = 100; k_redir = 0;
    k_dmin = 1; k_dmax = 1; err_nth = 0;
    ebrk_addr = '1; one_redir = 0;
    repeat (2) tick();
  endtask

  task automatic rst_off();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst_n = 1;
    #1;
    chk("idle_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    chk("first_req", 64'(imem_req_valid), 64'd1);
  endtask

  int          hs0;
  int          c_prev;
  int          b;
  logic [31:0] h_i;
  logic [63:0] h_pc;

  initial begin
    // back-to-back sequential fetch, one instruction per 3 cycles
    rst_on();
    rst_off();
    hs0 = hs_n;
    wait_hs(hs0 + 1, 20, "seq_first");
    c_prev = hs_cyc;
    for (int i = 2; i <= 4; i++) begin
      wait_hs(hs0 + i, 20, "seq_next");
      chk("seq_period", 64'(hs_cyc - c_prev), 64'd3);
      c_prev = hs_cyc;
    end

    // decoder stall in OUT
    k_irdy = 0;
    b = 0;
    while (!(inst_valid && !inst_ready) && b < 30) begin
      tick();
      b++;
    end
    chk("hold_reached", 64'(inst_valid && !inst_ready), 64'd1);
    h_i = inst;
    h_pc = inst_pc;
    hs0 = hs_n;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_inst", 64'(inst), 64'(h_i));
      chk("hold_pc", inst_pc, h_pc);
      chk("hold_no_req", 64'(imem_req_valid), 64'd0);
    end
    k_irdy = 100;
    wait_hs(hs0 + 2, 20, "hold_release");

    // redirect while a fetch is outstanding
    k_dmin = 2; k_dmax = 2;
    b = 0;
    while (!(imem_req_valid && imem_req_ready) && b < 20) begin
      tick();
      b++;
    end
    one_redir_pc = 64'h0000_0000_8000_1000;
    one_redir = 1;
    tick();
    b = 0;
    while (!(imem_req_valid && imem_req_ready) && b < 20) begin
      tick();
      b++;
    end
    chk("redir_wait_addr", imem_req_addr, 64'h0000_0000_8000_1000);
    hs0 = hs_n;
    wait_hs(hs0 + 1, 30, "redir_wait_deliver");

    // pc wraps at 2^64
    k_dmin = 1; k_dmax = 1;
    one_redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    one_redir = 1;
    hs0 = hs_n;
    wait_hs(hs0 + 4, 60, "wrap");

    // randomized traffic
    k_rdy = 70; k_irdy = 60; k_redir = 4; k_dmin = 1; k_dmax = 3;
    repeat (3000) tick();
    k_redir = 0; k_rdy = 100; k_irdy = 100;
    hs0 = hs_n;
    wait_hs(hs0 + 3, 60, "random_drain");

    // response error on the second fetch
    rst_on();
    err_nth = 2;
    hs0 = hs_n;
    rst_off();
    repeat (20) tick();
    chk("err_delivered", 64'(hs_n - hs0), 64'd1);
    chk("err_fault", 64'(fetch_fault), 64'd1);
    chk("err_halted", 64'(halted), 64'd1);
    chk("err_inst_valid", 64'(inst_valid), 64'd0);
    one_redir_pc = 64'h0000_0000_8000_2000;
    one_redir = 1;
    count_req(10, "err_no_req");
    chk("err_still_halted", 64'(halted), 64'd1);

    // misaligned redirect
    rst_on();
    rst_off();
    hs0 = hs_n;
    wait_hs(hs0 + 1, 20, "mis_first");
    one_redir_pc = 64'h0000_0000_8000_0002;
    one_redir = 1;
    tick();
    chk("mis_fault_pre", 64'(fetch_fault), 64'd0);
    tick();
    chk("mis_fault", 64'(fetch_fault), 64'd1);
    chk("mis_halted", 64'(halted), 64'd1);
    count_req(10, "mis_no_req");

    // ebreak at the third instruction
    rst_on();
    ebrk_addr = RPC + 64'd8;
    rst_off();
    hs0 = hs_n;
    wait_hs(hs0 + 3, 40, "ebrk_reach");
`ifdef YSYX_22040386_IFU_EBREAK_HALT_EN
    tick();
    chk("ebrk_halted", 64'(halted), 64'd1);
    chk("ebrk_fault", 64'(fetch_fault), 64'd0);
    count_req(10, "ebrk_no_req");
    chk("ebrk_no_more", 64'(hs_n - hs0), 64'd3);
`else
    wait_hs(hs0 + 4, 20, "ebrk_continue");
    chk("ebrk_not_halted", 64'(halted), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
